// File: rtl/jk_seq_pkg.sv
// +-------------------------------------------------------------------+
// | jk_seq_pkg : count modes, FSM states and Gray helpers for jk_seq   |
// | Rev 1.0                                                            |
// +-------------------------------------------------------------------+
`default_nettype none

package jk_seq_pkg;

  typedef enum logic [1:0] {
    MODE_UP   = 2'b00,
    MODE_DN   = 2'b01,
    MODE_GRAY = 2'b10,
    MODE_ROT  = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  // Helpers work on a fixed 32-bit container; callers zero-extend and truncate.
  localparam int unsigned FN_W = 32;

  function automatic logic [FN_W-1:0] bin2gray(input logic [FN_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [FN_W-1:0] gray2bin(input logic [FN_W-1:0] g);
    logic [FN_W-1:0] b;
    b[FN_W-1] = g[FN_W-1];
    for (int i = FN_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

`default_nettype wire

// File: rtl/jk_seq_controller_bank.sv
// +-------------------------------------------------------------------+
// | jk_bank : WIDTH JK state cells, sync active-low reset to preset    |
// | Rev 1.0                                                            |
// +-------------------------------------------------------------------+
`default_nettype none

module jk_bank #(
  parameter int              WIDTH       = 4,
  parameter logic [WIDTH-1:0] RESET_STATE = '0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] j_i,
  input  logic [WIDTH-1:0] k_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] q_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      q_q <= RESET_STATE;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        case ({j_i[i], k_i[i]})
          2'b01:   q_q[i] <= 1'b0;
          2'b10:   q_q[i] <= 1'b1;
          2'b11:   q_q[i] <= ~q_q[i];
          default: q_q[i] <= q_q[i];
        endcase
      end
    end
  end

  assign q_o = q_q;

endmodule

`default_nettype wire

// File: rtl/jk_seq_controller.sv
// +-------------------------------------------------------------------+
// | jk_seq_controller : load/run/stop sequencer over a JK state bank   |
// | Rev 1.0                                                            |
// +-------------------------------------------------------------------+
`default_nettype none

module jk_seq_controller
  import jk_seq_pkg::*;
#(
  parameter int               WIDTH       = 4,
  parameter logic [WIDTH-1:0] RESET_STATE = '0
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             start,
  input  logic             load,
  input  logic             stop,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] j_vec,
  output logic [WIDTH-1:0] k_vec,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             done,
  output logic             wrap
);

  state_e           state_q;
  mode_e            mode_q;
  logic [WIDTH-1:0] limit_q;
  logic             busy_q, done_q, wrap_q;

  logic [WIDTH-1:0] step_d, gray_bin_d, nxt_d;
  logic             wrap_d, at_limit;

  always_comb begin
    step_d     = q;
    wrap_d     = 1'b0;
    gray_bin_d = WIDTH'(gray2bin(FN_W'(q))) + 1'b1;
    case (mode_q)
      MODE_UP: begin
        step_d = q + 1'b1;
        wrap_d = &q;
      end
      MODE_DN: begin
        step_d = q - 1'b1;
        wrap_d = ~|q;
      end
      MODE_GRAY: begin
        step_d = WIDTH'(bin2gray(FN_W'(gray_bin_d)));
        wrap_d = (step_d == '0);
      end
      MODE_ROT: begin
        step_d = {q[WIDTH-2:0], q[WIDTH-1]};
      end
      default: begin
        step_d = q;
      end
    endcase
  end

  assign at_limit = (q == limit_q);

  always_comb begin
    nxt_d = q;
    if (state_q == ST_IDLE && load) begin
      nxt_d = load_val;
    end else if (state_q == ST_RUN && !stop && !at_limit) begin
      nxt_d = step_d;
    end
  end

  // Set only bits that rise, clear only bits that fall: J=K=1 never occurs.
  assign j_vec = nxt_d & ~q;
  assign k_vec = q & ~nxt_d;

  jk_bank #(
    .WIDTH       (WIDTH),
    .RESET_STATE (RESET_STATE)
  ) u_bank (
    .clk_i  (CLK),
    .rst_ni (Reset),
    .j_i    (j_vec),
    .k_i    (k_vec),
    .q_o    (q)
  );

  always_ff @(posedge CLK) begin
    if (!Reset) begin
      state_q <= ST_IDLE;
      mode_q  <= MODE_UP;
      limit_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      wrap_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start && !load) begin
            state_q <= ST_RUN;
            busy_q  <= 1'b1;
            mode_q  <= mode_e'(mode);
            limit_q <= limit;
          end
        end
        ST_RUN: begin
          // Abort wins over a coincident terminal count.
          if (stop) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end else if (at_limit) begin
            state_q <= ST_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            wrap_q <= wrap_d;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign wrap = wrap_q;

endmodule

`default_nettype wire
